// File: rtl/led_pkg.sv
// led_pkg -- constants shared by the key conditioner and the LED rotator.
//   SPEED_W       width of the speed index (0..3)
//   PRESS_*       bit positions inside the press pulse vector
//   period_of()   speed index -> terminal count of the downstream step counter
//                 (the rotator steps every period+1 cycles)
package led_pkg;

  localparam int SPEED_W = 2;
  typedef logic [SPEED_W-1:0] speed_t;

  localparam speed_t SPEED_MIN   = 2'd0;
  localparam speed_t SPEED_MAX   = 2'd3;
  localparam speed_t SPEED_RESET = 2'd1;

  localparam int PRESS_W     = 3;
  localparam int PRESS_START = 0;
  localparam int PRESS_UP    = 1;
  localparam int PRESS_DOWN  = 2;

  // Step periods at 100 MHz: 2 s, 1 s, 0.5 s, 0.25 s.
  localparam logic [31:0] PERIOD_S0 = 32'd199_999_999;
  localparam logic [31:0] PERIOD_S1 = 32'd99_999_999;
  localparam logic [31:0] PERIOD_S2 = 32'd49_999_999;
  localparam logic [31:0] PERIOD_S3 = 32'd24_999_999;

  function automatic logic [31:0] period_of(input speed_t s);
    logic [31:0] p;
    case (s)
      2'd0:    p = PERIOD_S0;
      2'd1:    p = PERIOD_S1;
      2'd2:    p = PERIOD_S2;
      default: p = PERIOD_S3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce -- one raw push button to a clean one-cycle press pulse.
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   key         raw active-high button, asynchronous to clk
//   press       one-cycle pulse when the debounced level goes 0->1
//   long_pulse  one-cycle pulse once the debounced level has been high for
//               LONG_CYCLES cycles (only when LONG_EN, otherwise tied low)
// The key is double-flopped, then the debounced level only follows the
// synchronized input after DB_CYCLES consecutive disagreeing cycles.
module key_debounce
  import led_pkg::*;
#(
  parameter int DB_CYCLES   = 2_000_000,
  parameter int LONG_CYCLES = 100_000_000,
  parameter bit LONG_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press,
  output logic long_pulse
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_reg;
  logic            sync2_reg;
  logic            level_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            press_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      level_reg  <= 1'b0;
      db_cnt_reg <= '0;
      press_reg  <= 1'b0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        // Last disagreeing cycle: accept the new level; a rising accept
        // produces the press pulse alongside the level change.
        if (db_cnt_reg == DB_LAST) begin
          level_reg  <= sync2_reg;
          db_cnt_reg <= '0;
          press_reg  <= sync2_reg;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        // Any agreeing cycle means the input bounced back: start over.
        db_cnt_reg <= '0;
      end
    end
  end

  assign press = press_reg;

  generate
    if (LONG_EN) begin : g_long
      localparam int LG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
      localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

      logic [LG_W-1:0] hold_cnt_reg;
      logic            fired_reg;
      logic            long_reg;

      // The held counter stops once the long event has fired, so the event
      // happens at most once per press; release clears both.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hold_cnt_reg <= '0;
          fired_reg    <= 1'b0;
          long_reg     <= 1'b0;
        end else begin
          long_reg <= 1'b0;
          if (!level_reg) begin
            hold_cnt_reg <= '0;
            fired_reg    <= 1'b0;
          end else if (!fired_reg) begin
            if (hold_cnt_reg == LG_LAST) begin
              long_reg  <= 1'b1;
              fired_reg <= 1'b1;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
        end
      end

      assign long_pulse = long_reg;
    end else begin : g_no_long
      assign long_pulse = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner -- three raw buttons to run/speed/period control.
//   clk        system clock, 100 MHz, rising edge
//   rst        asynchronous active-low reset
//   key_start  raw start/pause button (short press toggles run,
//              long press forces run=0 and speed=1)
//   key_up     raw speed-up button (saturates at 3)
//   key_down   raw speed-down button (saturates at 0)
//   run        rotator advances while high
//   speed      current speed index 0..3
//   period     step-counter terminal count derived from speed
//   press      registered one-cycle accepted-press pulses {down, up, start}
module key_conditioner
  import led_pkg::*;
#(
  parameter int DB_CYCLES   = 2_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start,
  input  logic               key_up,
  input  logic               key_down,
  output logic               run,
  output logic [SPEED_W-1:0] speed,
  output logic [31:0]        period,
  output logic [PRESS_W-1:0] press
);

  logic [PRESS_W-1:0] keys;
  logic [PRESS_W-1:0] db_press;
  logic [PRESS_W-1:0] db_long;
  logic               unused_long;

  assign keys[PRESS_START] = key_start;
  assign keys[PRESS_UP]    = key_up;
  assign keys[PRESS_DOWN]  = key_down;

  genvar gi;
  generate
    for (gi = 0; gi < PRESS_W; gi++) begin : g_key
      key_debounce #(
        .DB_CYCLES  (DB_CYCLES),
        .LONG_CYCLES(LONG_CYCLES),
        .LONG_EN    (gi == PRESS_START)
      ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key       (keys[gi]),
        .press     (db_press[gi]),
        .long_pulse(db_long[gi])
      );
    end
  endgenerate

  // Only the start key has long-press detection; the other two outputs are
  // constant zero.
  assign unused_long = db_long[PRESS_UP] ^ db_long[PRESS_DOWN];

  logic               run_reg;
  speed_t             speed_reg;
  logic [31:0]        period_reg;
  logic [PRESS_W-1:0] press_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg    <= 1'b0;
      speed_reg  <= SPEED_RESET;
      period_reg <= period_of(SPEED_RESET);
      press_reg  <= '0;
    end else begin
      press_reg  <= db_press;
      period_reg <= period_of(speed_reg);
      if (db_long[PRESS_START]) begin
        // Long press is the "home" gesture: it wins over everything else.
        run_reg   <= 1'b0;
        speed_reg <= SPEED_RESET;
      end else begin
        if (db_press[PRESS_START]) begin
          run_reg <= ~run_reg;
        end
        // Up and down together cancel out.
        if (db_press[PRESS_UP] && !db_press[PRESS_DOWN]) begin
          if (speed_reg != SPEED_MAX) speed_reg <= speed_reg + 1'b1;
        end else if (db_press[PRESS_DOWN] && !db_press[PRESS_UP]) begin
          if (speed_reg != SPEED_MIN) speed_reg <= speed_reg - 1'b1;
        end
      end
    end
  end

  assign run    = run_reg;
  assign speed  = speed_reg;
  assign period = period_reg;
  assign press  = press_reg;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  logic        clk;
  logic        rst;
  logic        key_start;
  logic        key_up;
  logic        key_down;
  logic        run;
  logic [1:0]  speed;
  logic [31:0] period;
  logic [2:0]  press;

  key_conditioner #(
    .DB_CYCLES  (4),
    .LONG_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_start(key_start),
    .key_up   (key_up),
    .key_down (key_down),
    .run      (run),
    .speed    (speed),
    .period   (period),
    .press    (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pulse monitor, sampled on the falling edge.
  int         pulse_cnt[3];
  int         multi_cnt = 0;
  int         long_evt  = 0;
  logic [2:0] prev_press = 3'b000;
  logic [1:0] prev_speed = 2'd1;

  always @(negedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (press[b]) pulse_cnt[b] = pulse_cnt[b] + 1;
      if (press[b] && prev_press[b]) multi_cnt = multi_cnt + 1;
    end
    if (prev_speed == 2'd3 && speed == 2'd1) long_evt = long_evt + 1;
    prev_press = press;
    prev_speed = speed;
  end

  typedef struct {
    logic [2:0]  keys;      // {down, up, start}
    logic        exp_run;
    logic [1:0]  exp_speed;
    logic [31:0] exp_period;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
  endtask

  int p0, p1, p2, l0, lat, rise_at, fall_at;

  initial begin
    for (int b = 0; b < 3; b++) pulse_cnt[b] = 0;
    rst = 1'b0; key_start = 1'b0; key_up = 1'b0; key_down = 1'b0;

    vecs[0]  = '{3'b010, 1'b0, 2'd2, 32'd49_999_999};
    vecs[1]  = '{3'b010, 1'b0, 2'd3, 32'd24_999_999};
    vecs[2]  = '{3'b010, 1'b0, 2'd3, 32'd24_999_999};
    vecs[3]  = '{3'b010, 1'b0, 2'd3, 32'd24_999_999};
    vecs[4]  = '{3'b100, 1'b0, 2'd2, 32'd49_999_999};
    vecs[5]  = '{3'b100, 1'b0, 2'd1, 32'd99_999_999};
    vecs[6]  = '{3'b100, 1'b0, 2'd0, 32'd199_999_999};
    vecs[7]  = '{3'b100, 1'b0, 2'd0, 32'd199_999_999};
    vecs[8]  = '{3'b100, 1'b0, 2'd0, 32'd199_999_999};
    vecs[9]  = '{3'b110, 1'b0, 2'd0, 32'd199_999_999};
    vecs[10] = '{3'b010, 1'b0, 2'd1, 32'd99_999_999};
    vecs[11] = '{3'b110, 1'b0, 2'd1, 32'd99_999_999};
    vecs[12] = '{3'b001, 1'b1, 2'd1, 32'd99_999_999};
    vecs[13] = '{3'b001, 1'b0, 2'd1, 32'd99_999_999};

    // Reset values, during and after reset.
    wait_cycles(3);
    check("rst_run", {31'd0, run}, 32'd0);
    check("rst_speed", {30'd0, speed}, 32'd1);
    check("rst_period", period, 32'd99_999_999);
    check("rst_press", {29'd0, press}, 32'd0);
    rst = 1'b1;
    wait_cycles(3);
    check("post_rst_speed", {30'd0, speed}, 32'd1);
    check("post_rst_period", period, 32'd99_999_999);

    // Clean presses: saturation, simultaneous up/down, start toggle.
    for (int i = 0; i < 14; i++) begin
      p0 = pulse_cnt[0]; p1 = pulse_cnt[1]; p2 = pulse_cnt[2];
      {key_down, key_up, key_start} = vecs[i].keys;
      wait_cycles(10);
      {key_down, key_up, key_start} = 3'b000;
      wait_cycles(10);
      check($sformatf("vec%0d_run", i), {31'd0, run}, {31'd0, vecs[i].exp_run});
      check($sformatf("vec%0d_speed", i), {30'd0, speed}, {30'd0, vecs[i].exp_speed});
      check($sformatf("vec%0d_period", i), period, vecs[i].exp_period);
      check($sformatf("vec%0d_pulse_start", i), pulse_cnt[0] - p0, {31'd0, vecs[i].keys[0]});
      check($sformatf("vec%0d_pulse_up", i), pulse_cnt[1] - p1, {31'd0, vecs[i].keys[1]});
      check($sformatf("vec%0d_pulse_down", i), pulse_cnt[2] - p2, {31'd0, vecs[i].keys[2]});
      $display("vec %0d keys=%b run=%0d speed=%0d period=%0d", i, vecs[i].keys, run, speed, period);
    end

    // Raw edge to press pulse latency: 2 sync + DB + 1 = 7 (+/-1).
    key_start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (press[0]) begin
        lat = n;
        break;
      end
    end
    key_start = 1'b0;
    check_range("latency", lat, 6, 8);
    wait_cycles(12);
    check("latency_run", {31'd0, run}, 32'd1);
    $display("latency press cycles=%0d", lat);

    // Bounce: up toggles every 2 cycles for 20 cycles, then held.
    do_reset();
    p1 = pulse_cnt[1];
    for (int i = 0; i < 10; i++) begin
      key_up = (i % 2 == 0);
      wait_cycles(2);
    end
    check("bounce_no_early_pulse", pulse_cnt[1] - p1, 32'd0);
    key_up = 1'b1;
    wait_cycles(12);
    key_up = 1'b0;
    wait_cycles(10);
    check("bounce_pulses", pulse_cnt[1] - p1, 32'd1);
    check("bounce_speed", {30'd0, speed}, 32'd2);
    check("bounce_period", period, 32'd49_999_999);
    $display("bounce speed=%0d period=%0d", speed, period);

    // Long press at speed 3.
    key_up = 1'b1; wait_cycles(10); key_up = 1'b0; wait_cycles(10);
    check("long_pre_speed", {30'd0, speed}, 32'd3);
    l0 = long_evt; p0 = pulse_cnt[0];
    rise_at = 0; fall_at = 0;
    key_start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (run && rise_at == 0) rise_at = n;
      if (!run && rise_at != 0 && fall_at == 0) fall_at = n;
    end
    check_range("long_run_rise", rise_at, 6, 8);
    check_range("long_run_fall", fall_at, 21, 25);
    check("long_run", {31'd0, run}, 32'd0);
    check("long_speed", {30'd0, speed}, 32'd1);
    check("long_period", period, 32'd99_999_999);
    key_start = 1'b0;
    wait_cycles(15);
    check("long_events", long_evt - l0, 32'd1);
    check("long_start_pulses", pulse_cnt[0] - p0, 32'd1);
    check("long_release_run", {31'd0, run}, 32'd0);
    $display("long rise=%0d fall=%0d speed=%0d", rise_at, fall_at, speed);

    // Async reset mid-debounce of key_down.
    key_up = 1'b1; wait_cycles(10); key_up = 1'b0; wait_cycles(10);
    key_start = 1'b1; wait_cycles(10); key_start = 1'b0; wait_cycles(10);
    check("pre_arst_run", {31'd0, run}, 32'd1);
    check("pre_arst_speed", {30'd0, speed}, 32'd2);
    p2 = pulse_cnt[2];
    key_down = 1'b1;
    wait_cycles(3);
    #2 rst = 1'b0;
    #1;
    check("arst_run", {31'd0, run}, 32'd0);
    check("arst_speed", {30'd0, speed}, 32'd1);
    check("arst_period", period, 32'd99_999_999);
    check("arst_press", {29'd0, press}, 32'd0);
    @(negedge clk);
    key_down = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(15);
    check("arst_down_pulses", pulse_cnt[2] - p2, 32'd0);
    check("arst_after_speed", {30'd0, speed}, 32'd1);
    $display("async reset mid-debounce run=%0d speed=%0d", run, speed);

    // Key held through reset release: full debounce, then one normal pulse.
    @(negedge clk);
    key_up = 1'b1;
    do_reset();
    p1 = pulse_cnt[1];
    wait_cycles(3);
    check("held_rst_early", pulse_cnt[1] - p1, 32'd0);
    wait_cycles(12);
    check("held_rst_pulse", pulse_cnt[1] - p1, 32'd1);
    check("held_rst_speed", {30'd0, speed}, 32'd2);
    key_up = 1'b0;
    wait_cycles(10);
    check("held_rst_release", pulse_cnt[1] - p1, 32'd1);
    $display("held through reset speed=%0d", speed);

    check("single_cycle_pulses", multi_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
